// File: rtl/wb_pixel_initiator.sv
// Wishbone classic initiator: turns command/response handshakes into single
// read/write bus cycles, with an address-window check and an ack timeout.
module wb_pixel_initiator #(
  parameter logic [3:0]  ADDR_PREFIX    = 4'h3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Last counter value before expiry; cyc/stb therefore stay high TIMEOUT_CYCLES cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            cyc_d, we_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [3:0]      sel_d;
  logic [31:0]     adr_d, dat_d, rsp_dat_d;

  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    cyc_d         = wbm_cyc_o;
    we_d          = wbm_we_o;
    sel_d         = wbm_sel_o;
    adr_d         = wbm_adr_o;
    dat_d         = wbm_dat_o;
    rsp_valid_d   = rsp_valid;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    rsp_dat_d     = rsp_dat;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d  = cmd_we;
          adr_d = cmd_adr;
          dat_d = cmd_dat;
          sel_d = cmd_sel;
          if (cmd_adr[31:28] == ADDR_PREFIX) begin
            state_d = BUS;
            cyc_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_dat_d     = '0;
          end
        end
      end

      BUS: begin
        cnt_d = cnt_q + TO_W'(1);
        // Ack is tested first so an ack on the expiry edge still completes cleanly.
        if (wbm_ack_i) begin
          state_d       = RESP;
          cyc_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_dat_d     = wbm_we_o ? '0 : wbm_dat_i;
        end else if (cnt_q == TO_LAST) begin
          state_d       = RESP;
          cyc_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_dat_d     = '0;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_dat     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbm_cyc_o   <= cyc_d;
      wbm_stb_o   <= cyc_d;
      wbm_we_o    <= we_d;
      wbm_sel_o   <= sel_d;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_dat     <= rsp_dat_d;
    end
  end

endmodule

// File: tb/tb_wb_pixel_initiator.sv
// Directed testbench for wb_pixel_initiator with TIMEOUT_CYCLES=8.
module tb_wb_pixel_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int   cyc_total = 0;
  int   cyc_rise  = 0;
  logic cyc_prev  = 1'b0;

  wb_pixel_initiator #(
    .ADDR_PREFIX   (4'h3),
    .TIMEOUT_CYCLES(8),
    .TO_W          (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with cyc high and the number of separate cyc pulses.
  always @(negedge clk) begin
    if (wbm_cyc_o) cyc_total <= cyc_total + 1;
    if (wbm_cyc_o && !cyc_prev) cyc_rise <= cyc_rise + 1;
    cyc_prev <= wbm_cyc_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one command for exactly one edge; the DUT must be in IDLE.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    step();
    cmd_valid = 1'b0;
  endtask

  // After acceptance: ack low for `waits` cycles, then ack high for one edge.
  task automatic slave_ack(input int waits, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) step();
    wbm_ack_i = 1'b1;
    wbm_dat_i = rdata;
    step();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hBAD0_BAD0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_err, rsp_timeout, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {rsp_err, rsp_timeout, wbm_cyc_o, wbm_stb_o, wbm_we_o}); else pass_cnt++;
    total_cnt++; if ({wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat} !== 100'b0)
      $display("FAIL reset_data: got %h want 0", {wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat}); else pass_cnt++;
  endtask

  task automatic test_write();
    int c0 = cyc_total;
    int r0 = cyc_rise;
    issue(1'b1, 32'h3000_0000, 32'h0000_0025, 4'hF);
    total_cnt++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) $display("FAIL wr_cyc_stb: got %b%b want 11", wbm_cyc_o, wbm_stb_o); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL wr_cmd_ready: got %b want 0", cmd_ready); else pass_cnt++;
    total_cnt++; if ({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== {1'b1, 4'hF, 32'h3000_0000, 32'h0000_0025})
      $display("FAIL wr_bus_fields: got %b %h %h %h want 1 f 30000000 00000025", wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o); else pass_cnt++;
    slave_ack(1, 32'hFFFF_FFFF);
    total_cnt++; if (wbm_cyc_o !== 1'b0) $display("FAIL wr_cyc_drop: got %b want 0", wbm_cyc_o); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
      $display("FAIL wr_rsp: got v%b e%b t%b want v1 e0 t0", rsp_valid, rsp_err, rsp_timeout); else pass_cnt++;
    total_cnt++; if (rsp_dat !== 32'h0) $display("FAIL wr_rsp_dat: got %h want 00000000", rsp_dat); else pass_cnt++;
    total_cnt++; if (cyc_total - c0 !== 2 || cyc_rise - r0 !== 1)
      $display("FAIL wr_cyc_len: got %0d cycles %0d pulses want 2 cycles 1 pulse", cyc_total - c0, cyc_rise - r0); else pass_cnt++;
    consume();
    total_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL wr_done: got v%b r%b want v0 r1", rsp_valid, cmd_ready); else pass_cnt++;
    total_cnt++; if (wbm_dat_o !== 32'h0000_0025 || wbm_we_o !== 1'b1) $display("FAIL wr_hold: got %h %b want 00000025 1", wbm_dat_o, wbm_we_o); else pass_cnt++;
  endtask

  task automatic test_read();
    int c0 = cyc_total;
    issue(1'b0, 32'h3000_0000, 32'h1234_5678, 4'hF);
    total_cnt++; if (wbm_we_o !== 1'b0) $display("FAIL rd_we: got %b want 0", wbm_we_o); else pass_cnt++;
    slave_ack(3, 32'h0155_5AA1);
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL rd_rsp: got v%b e%b want v1 e0", rsp_valid, rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_dat !== 32'h0155_5AA1) $display("FAIL rd_rsp_dat: got %h want 01555aa1", rsp_dat); else pass_cnt++;
    total_cnt++; if (cyc_total - c0 !== 4) $display("FAIL rd_cyc_len: got %0d want 4", cyc_total - c0); else pass_cnt++;
    consume();
  endtask

  task automatic test_addr_reject();
    int c0 = cyc_total;
    issue(1'b0, 32'h2000_0000, 32'h0, 4'hF);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rej_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0) $display("FAIL rej_err: got e%b t%b want e1 t0", rsp_err, rsp_timeout); else pass_cnt++;
    total_cnt++; if (rsp_dat !== 32'h0) $display("FAIL rej_rsp_dat: got %h want 00000000", rsp_dat); else pass_cnt++;
    step();
    total_cnt++; if (cyc_total - c0 !== 0 || wbm_stb_o !== 1'b0) $display("FAIL rej_no_bus: got %0d cyc cycles want 0", cyc_total - c0); else pass_cnt++;
    consume();
  endtask

  task automatic test_timeout();
    int c0 = cyc_total;
    int n  = 0;
    issue(1'b0, 32'h3000_0040, 32'h0, 4'h1);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL to_rsp_valid: got %b want 1 within 20 cycles", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_dat !== 32'h0)
      $display("FAIL to_rsp: got e%b t%b d%h want e1 t1 d00000000", rsp_err, rsp_timeout, rsp_dat); else pass_cnt++;
    total_cnt++; if (cyc_total - c0 !== 8) $display("FAIL to_cyc_len: got %0d want 8", cyc_total - c0); else pass_cnt++;
    consume();
    // Ack arriving on the expiry edge must win.
    c0 = cyc_total;
    issue(1'b0, 32'h3000_0044, 32'h0, 4'hF);
    slave_ack(7, 32'hCAFE_F00D);
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
      $display("FAIL to_ack_wins: got v%b e%b t%b want v1 e0 t0", rsp_valid, rsp_err, rsp_timeout); else pass_cnt++;
    total_cnt++; if (rsp_dat !== 32'hCAFE_F00D || cyc_total - c0 !== 8)
      $display("FAIL to_ack_data: got %h %0d cycles want cafef00d 8 cycles", rsp_dat, cyc_total - c0); else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    slave_ack(0, 32'hDEAD_BEEF);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0010;
    cmd_dat   = 32'h0000_0011;
    cmd_sel   = 4'h3;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) bad++;
      step();
    end
    total_cnt++; if (bad !== 0) $display("FAIL b2b_hold: got %0d unstable cycles want 0", bad); else pass_cnt++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0)
      $display("FAIL b2b_release: got v%b r%b c%b want v0 r1 c0", rsp_valid, cmd_ready, wbm_cyc_o); else pass_cnt++;
    step();
    cmd_valid = 1'b0;
    total_cnt++; if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0010 || wbm_sel_o !== 4'h3 || wbm_we_o !== 1'b1)
      $display("FAIL b2b_next: got c%b %h %h %b want c1 30000010 3 1", wbm_cyc_o, wbm_adr_o, wbm_sel_o, wbm_we_o); else pass_cnt++;
    slave_ack(0, 32'h0);
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0)
      $display("FAIL b2b_next_rsp: got v%b e%b %h want v1 e0 00000000", rsp_valid, rsp_err, rsp_dat); else pass_cnt++;
    consume();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0001)
      $display("FAIL rst_bus: got %b want 0001", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}); else pass_cnt++;
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    step();
    total_cnt++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL rst_bus_stray_ack: got v%b c%b r%b want v0 c0 r1", rsp_valid, wbm_cyc_o, cmd_ready); else pass_cnt++;
    issue(1'b1, 32'h5000_0000, 32'h0, 4'hF);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rst_resp_setup: got %b want 1", rsp_valid); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0001)
      $display("FAIL rst_resp: got %b want 0001", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}); else pass_cnt++;
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    step();
    total_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL rst_resp_stray_ack: got v%b r%b want v0 r1", rsp_valid, cmd_ready); else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hBAD0_BAD0;
    test_reset();
    test_write();
    test_read();
    test_addr_reject();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
